led_activity_pwm: RTL and testbench
===================================

# led_activity_pwm

Parametrised multi-channel LED driver for the CADR MiSTer top level. It replaces the single hard-wired breathing counter that drives LED_USER. Each of CHANNELS outputs independently selects off, steady, breathing or activity-stretched mode, and all outputs are dimmed by one shared brightness value. Typical connections are LED_USER, LED_DISK[0] and LED_POWER[0], with activity strobes taken from the SD/disk and CPU paths.

## Interface
- CHANNELS, 3: number of LED channels, ≥1.
- PWM_BITS, 8: PWM resolution; also the width of the brightness and breathe level.
- BREATH_BITS, 27: width of the shared free-running counter; must be ≥ 2*PWM_BITS+1.
- STRETCH_BITS, 22: width of each channel's activity stretch counter.
- clk_sys, in, 1: system clock; the only clock.
- reset_n, in, 1: asynchronous, active-low reset.
- mode, in, 2*CHANNELS: per-channel mode; channel i uses bits [2i+1:2i].
- act, in, CHANNELS: per-channel activity strobe, level-sensitive, synchronous to clk_sys.
- brightness, in, PWM_BITS: global brightness cap.
- led, out, CHANNELS: LED drive, registered, active high.

## Operation
- Shared counter `bc` (BREATH_BITS wide) increments every cycle and wraps from all-ones to 0.
- Fields of `bc`:
  - pwm_cnt = bc[PWM_BITS-1:0]
  - phase = bc[BREATH_BITS-2 -: PWM_BITS]
  - dir = bc[BREATH_BITS-1]
- Breathe level: level = dir ? ~phase : phase. This is a triangle: it rises over the first half-period and falls over the second.
- Effective breathe level: eff = min(level, brightness).
- Per-channel stretch counter `sc[i]` (STRETCH_BITS wide):
  - Loads all-ones in any cycle where act[i]=1.
  - Otherwise decrements when nonzero, and holds at 0.
  - Runs in every mode, so a switch to mode 11 immediately shows pending activity.
- Next value of led[i], by mode:
  - 00, off: 0.
  - 01, steady: pwm_cnt < brightness.
  - 10, breathe: pwm_cnt < eff.
  - 11, activity: (sc[i] != 0 || act[i]) && pwm_cnt < brightness.
- brightness=0 forces every output to 0 in all modes. brightness=all-ones gives a duty of (2^PWM_BITS − 1)/2^PWM_BITS, never 100%.

## Timing
- Reset values: bc=0, all sc=0, led=0. Asynchronous assertion; the first count occurs on the first clk_sys edge after reset_n deasserts.
- led has a latency of 1 cycle from the bc, mode, act and brightness values that form it.
- Mode and brightness changes take effect on the next edge. There is no glitch filtering or PWM-period alignment.
- Boundary conditions:
  - act[i] in the cycle where sc[i]=1: the reload wins, and sc[i] goes to all-ones, not 0.
  - act[i] held high: sc[i] stays all-ones and the LED stays lit.
  - After the last act[i] pulse: the LED stays eligible for exactly 2^STRETCH_BITS − 1 further cycles plus the 1-cycle output latency.
- bc wrap: dir returns to 0 and phase to 0, so level drops to 0 and the triangle is continuous at the wrap.
- Reset asserted mid-operation: all state clears asynchronously and led drops to 0 without waiting for a clock edge.

## Configuration
- LEDPWM_GAMMA_EN:
  - When defined, the breathe level is square-law corrected before the cap: level_g = (level*level) >> PWM_BITS, and eff = min(level_g, brightness).
  - When undefined, level is used directly (linear breathing).
- The macro affects only mode 10. Modes 00, 01 and 11 are identical with or without it.

## Test plan
All scenarios use CHANNELS=3, PWM_BITS=4, BREATH_BITS=9, STRETCH_BITS=4, LEDPWM_GAMMA_EN undefined unless stated.

- Reset: hold reset_n=0 with mode=all 01 and brightness=15 → led=000 throughout. Release → after 1 cycle led=111 for pwm_cnt 0–14 and led=000 at pwm_cnt=15.
- Steady dimming: mode ch0=01, brightness=4 → led[0] high for exactly 4 of every 16 cycles, on pwm_cnt 0–3. brightness=0 → led[0] never high.
- Breathe: ch1=10, brightness=15 →
  - With bc=0x050 (dir=0, phase=5): led[1] high for pwm_cnt 0–4.
  - With bc=0x150 (dir=1, phase=5, level=10): led[1] high for pwm_cnt 0–9.
  - brightness=3 caps each of these windows at pwm_cnt 0–2.
- Activity stretch: ch2=11, brightness=15, single 1-cycle act[2] pulse → sc[2] counts 15→0, led[2] follows PWM for 16 cycles, then stays 0. A second pulse in the cycle where sc=1 reloads sc to 15.
- Mode switch: ch0 in 11 with sc[0]=7, mode switched to 00 → led[0]=0 next cycle. Switched back to 11 four cycles later → led[0] resumes with sc[0]=3.
- Gamma: define LEDPWM_GAMMA_EN, ch1=10, phase=8, dir=0 → level_g=4, so led[1] high for pwm_cnt 0–3 only. The same case with the macro undefined gives 0–7.

Source files
------------

// File: rtl/led_activity_pwm.sv
// ---------------------------------------------------------------------------
// led_activity_pwm
//
// Multi-channel LED driver. One shared free-running counter supplies the
// PWM ramp and a slow triangle "breathing" level. Each channel picks one of
// four modes, and one global brightness value caps every mode.
//   mode 00 : off
//   mode 01 : steady, PWM duty = brightness / 2^PWM_BITS
//   mode 10 : breathing, duty follows the triangle capped by brightness
//   mode 11 : activity, steady PWM while the channel's stretch timer runs
//
// Optional feature macro: LEDPWM_GAMMA_EN. When it is defined, the breathing
// level is square-law corrected before the brightness cap. Only mode 10 is
// affected.
//
// Ports
//   clk_sys    : system clock, the only clock
//   reset_n    : asynchronous active-low reset
//   mode       : 2 bits per channel, channel i uses [2i+1:2i]
//   act        : per-channel activity strobe, level-sensitive
//   brightness : global brightness cap
//   led        : registered LED drive, active high
// ---------------------------------------------------------------------------
module led_activity_pwm #(
    parameter int CHANNELS     = 3,
    parameter int PWM_BITS     = 8,
    parameter int BREATH_BITS  = 27,
    parameter int STRETCH_BITS = 22
) (
    input  logic                    clk_sys,
    input  logic                    reset_n,
    input  logic [2*CHANNELS-1:0]   mode,
    input  logic [CHANNELS-1:0]     act,
    input  logic [PWM_BITS-1:0]     brightness,
    output logic [CHANNELS-1:0]     led
);

    logic [BREATH_BITS-1:0]                  r_bc;
    logic [CHANNELS-1:0][STRETCH_BITS-1:0]   r_sc;
    logic [CHANNELS-1:0]                     r_led;

    logic [PWM_BITS-1:0]  w_pwmCnt;
    logic [PWM_BITS-1:0]  w_phase;
    logic                 w_dir;
    logic [PWM_BITS-1:0]  w_level;
    logic [PWM_BITS-1:0]  w_levelShaped;
    logic [PWM_BITS-1:0]  w_eff;
    logic                 w_pwmOn;
    logic                 w_breatheOn;
    logic [CHANNELS-1:0]  w_ledNext;

    // Fields of the shared counter: the low bits are the PWM ramp, the
    // phase sits just under the top bit, and the top bit picks whether the
    // triangle is rising or falling. Inverting the phase on the falling half
    // keeps the triangle continuous both at mid-period and at the wrap.
    assign w_pwmCnt = r_bc[PWM_BITS-1:0];
    assign w_phase  = r_bc[BREATH_BITS-2 -: PWM_BITS];
    assign w_dir    = r_bc[BREATH_BITS-1];
    assign w_level  = w_dir ? ~w_phase : w_phase;

`ifdef LEDPWM_GAMMA_EN
    // Square-law correction so that the breathing looks perceptually even;
    // keep only the upper half of the full-width product.
    logic [2*PWM_BITS-1:0] w_levelSq;
    assign w_levelSq     = {{PWM_BITS{1'b0}}, w_level} * {{PWM_BITS{1'b0}}, w_level};
    assign w_levelShaped = PWM_BITS'(w_levelSq >> PWM_BITS);
`else
    assign w_levelShaped = w_level;
`endif

    assign w_eff       = (w_levelShaped < brightness) ? w_levelShaped : brightness;
    assign w_pwmOn     = (w_pwmCnt < brightness);
    assign w_breatheOn = (w_pwmCnt < w_eff);

    // Shared free-running counter; wraps naturally from all-ones to zero.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_bc <= '0;
        end else begin
            r_bc <= r_bc + {{(BREATH_BITS-1){1'b0}}, 1'b1};
        end
    end

    // Per-channel stretch timers. They run in every mode, so switching a
    // channel into activity mode immediately shows recent activity. A strobe
    // always reloads, even in the cycle where the timer would reach zero.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_sc <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (act[i]) begin
                    r_sc[i] <= '1;
                end else if (r_sc[i] != '0) begin
                    r_sc[i] <= r_sc[i] - {{(STRETCH_BITS-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    // Next LED value per channel, chosen by that channel's mode.
    always_comb begin
        w_ledNext = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            case (mode[2*i +: 2])
                2'b00:   w_ledNext[i] = 1'b0;
                2'b01:   w_ledNext[i] = w_pwmOn;
                2'b10:   w_ledNext[i] = w_breatheOn;
                default: w_ledNext[i] = ((r_sc[i] != '0) || act[i]) && w_pwmOn;
            endcase
        end
    end

    // Registered output so the LED pins are glitch-free.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_led <= '0;
        end else begin
            r_led <= w_ledNext;
        end
    end

    assign led = r_led;

endmodule

// File: tb/tb_led_activity_pwm.sv
// ---------------------------------------------------------------------------
// tb_led_activity_pwm
//
// Self-checking bench for led_activity_pwm with small parameters
// (3 channels, 4-bit PWM, 9-bit breathing counter, 4-bit stretch).
// The reference model works from the elapsed cycle count since reset and
// the cycle of the last activity strobe on each channel, and predicts the
// LED pattern one cycle ahead.
// ---------------------------------------------------------------------------
module tb_led_activity_pwm;

    localparam int CH   = 3;
    localparam int PB   = 4;
    localparam int BB   = 9;
    localparam int SB   = 4;
    localparam int PWMN = 1 << PB;
    localparam int STRETCH_LEN = (1 << SB) - 1;

    logic               clk_sys;
    logic               reset_n;
    logic [2*CH-1:0]    mode;
    logic [CH-1:0]      act;
    logic [PB-1:0]      brightness;
    logic [CH-1:0]      led;

    int totalChecks;
    int badChecks;
    int cyc;
    int lastAct [CH];

    led_activity_pwm #(
        .CHANNELS     (CH),
        .PWM_BITS     (PB),
        .BREATH_BITS  (BB),
        .STRETCH_BITS (SB)
    ) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .mode       (mode),
        .act        (act),
        .brightness (brightness),
        .led        (led)
    );

    // 10 ns clock; inputs change and outputs are sampled on the falling edge.
    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s cyc=%0d got=%b want=%b", tag, cyc, observed, expected);
        end
    endtask

    // Restart the model's notion of time and clear all activity history.
    task automatic modelReset();
        cyc = 0;
        for (int i = 0; i < CH; i++) lastAct[i] = -1000;
    endtask

    // Drive one cycle of inputs, predict the LED value that the next rising
    // edge registers, then compare at the following falling edge.
    task automatic applyStimulus(input logic [2*CH-1:0] m, input logic [CH-1:0] a, input logic [PB-1:0] b);
        logic [CH-1:0] expLed;
        int bcv, pwm, phase, dir, level, eff, md;
        bit live;
        mode       = m;
        act        = a;
        brightness = b;
        bcv   = cyc % (1 << BB);
        pwm   = bcv % PWMN;
        phase = (bcv / PWMN) % PWMN;
        dir   = bcv / (1 << (BB - 1));
        level = (dir != 0) ? (PWMN - 1 - phase) : phase;
`ifdef LEDPWM_GAMMA_EN
        level = (level * level) / PWMN;
`endif
        eff = (level < int'(b)) ? level : int'(b);
        expLed = '0;
        for (int i = 0; i < CH; i++) begin
            md   = int'(m[2*i +: 2]);
            live = a[i] || (cyc - lastAct[i] <= STRETCH_LEN);
            case (md)
                0: expLed[i] = 1'b0;
                1: expLed[i] = (pwm < int'(b));
                2: expLed[i] = (pwm < eff);
                default: expLed[i] = live && (pwm < int'(b));
            endcase
            if (a[i]) lastAct[i] = cyc;
        end
        @(negedge clk_sys);
        checkOutput("led", {5'b0, led}, {5'b0, expLed});
        cyc++;
    endtask

    task automatic runIdle(input int n, input logic [2*CH-1:0] m, input logic [PB-1:0] b);
        for (int k = 0; k < n; k++) applyStimulus(m, '0, b);
    endtask

    initial begin
        logic [2*CH-1:0] rMode;
        logic [PB-1:0]   rBright;
        logic [CH-1:0]   rAct;
        int              holdLeft;

        totalChecks = 0;
        badChecks   = 0;
        modelReset();
        reset_n    = 1'b0;
        mode       = 6'b010101;
        act        = '0;
        brightness = 4'd15;

        // Held in reset: outputs stay dark despite steady mode.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_sys);
            checkOutput("resetHold", {5'b0, led}, 8'd0);
        end
        reset_n = 1'b1;
        modelReset();

        // Steady at full brightness, then breathing with and without a cap.
        runIdle(40, 6'b010101, 4'd15);
        while (cyc < 'h060) applyStimulus(6'b001000, '0, 4'd15);
        while (cyc < 'h100) applyStimulus(6'b001000, '0, 4'd3);
        while (cyc < 'h160) applyStimulus(6'b001000, '0, 4'd15);
        while (cyc < 'h200) applyStimulus(6'b001000, '0, 4'd3);
        // Crosses the counter wrap.
        runIdle(40, 6'b001000, 4'd15);

        // Steady dimming and brightness zero.
        runIdle(32, 6'b000001, 4'd4);
        runIdle(16, 6'b010101, 4'd0);

        // Activity stretch on channel 2: single pulse, reload at the last
        // stretch cycle, and a long held strobe.
        applyStimulus(6'b110000, 3'b100, 4'd15);
        runIdle(20, 6'b110000, 4'd15);
        applyStimulus(6'b110000, 3'b100, 4'd15);
        runIdle(14, 6'b110000, 4'd15);
        applyStimulus(6'b110000, 3'b100, 4'd15);
        runIdle(20, 6'b110000, 4'd15);
        for (int k = 0; k < 10; k++) applyStimulus(6'b110000, 3'b100, 4'd15);
        runIdle(20, 6'b110000, 4'd15);

        // Mode switch on channel 0 while its stretch timer is running.
        applyStimulus(6'b000011, 3'b001, 4'd15);
        runIdle(8, 6'b000011, 4'd15);
        runIdle(4, 6'b000000, 4'd15);
        runIdle(20, 6'b000011, 4'd15);

        // Randomised traffic across all modes and brightness values.
        rMode    = 6'b111001;
        rBright  = 4'd15;
        holdLeft = 0;
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 49) == 0) rMode = 6'($urandom());
            if ($urandom_range(0, 79) == 0) begin
                case ($urandom_range(0, 3))
                    0: rBright = 4'd0;
                    1: rBright = 4'd15;
                    default: rBright = 4'($urandom());
                endcase
            end
            rAct = '0;
            for (int i = 0; i < CH; i++) rAct[i] = ($urandom_range(0, 29) == 0);
            if (holdLeft > 0) begin
                rAct[0] = 1'b1;
                holdLeft--;
            end else if ($urandom_range(0, 199) == 0) begin
                holdLeft = $urandom_range(2, 12);
            end
            applyStimulus(rMode, rAct, rBright);
        end

        // Asynchronous reset mid-operation: outputs clear without a clock edge.
        applyStimulus(6'b010101, 3'b111, 4'd15);
        #1;
        reset_n = 1'b0;
        #1;
        checkOutput("asyncReset", {5'b0, led}, 8'd0);
        @(negedge clk_sys);
        checkOutput("resetHold2", {5'b0, led}, 8'd0);
        reset_n = 1'b1;
        modelReset();
        // Stretch history must be gone after reset.
        runIdle(20, 6'b111111, 4'd15);
        runIdle(20, 6'b010101, 4'd15);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
